pixel_stream_reader: RTL and testbench
======================================

# pixel_stream_reader

Raster-order pixel source feeding the 7x7 window builder's `data_enable`/`data_in` pixel stream. On `start`, it reads one IMG_WIDTH x IMG_HEIGHT 8-bit frame from a synchronous-read frame RAM and emits the pixels one per accepted cycle. A two-entry skid buffer carries the stream under downstream backpressure. It then appends 3*IMG_WIDTH+3 zero pixels so the window centre reaches the last real pixel, and pulses `done`.

## Interface
- IMG_WIDTH, 64: pixels per line; range 7..1024.
- IMG_HEIGHT, 64: lines per frame; range 7..1024.
- ADDR_W, 12: frame RAM address width; must satisfy 2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT.
- Derived, not overridable: NPIX = IMG_WIDTH*IMG_HEIGHT; FLUSH_PIX = 3*IMG_WIDTH+3.

- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low; the block is in reset while `reset`==0.
- start  in  1  begin a frame; sampled only in IDLE.
- ready  in  1  downstream can accept a pixel this cycle.
- mem_rd_en  out  1  frame RAM read strobe; data returns on `mem_rdata` exactly 1 cycle later.
- mem_addr  out  ADDR_W  frame RAM read address, row*IMG_WIDTH+col.
- mem_rdata  in  8  frame RAM read data.
- pix_enable  out  1  pixel transferred this cycle; equals buffer_not_empty && ready. Connects to the window builder's `data_enable`.
- pix_data  out  8  buffer head; 0 when the buffer is empty. Connects to the window builder's `data_in`.
- frame_start  out  1  high with the pixel_enable beat of pixel 0.
- line_start  out  1  high with each image-pixel beat whose col==0; never during flush.
- busy  out  1  high from the cycle after `start` is accepted until `done`.
- done  out  1  one-cycle pulse after the last flush pixel transfers.

## Operation
- State machine:
  - IDLE: `busy`=0. `start`=1 moves to READ; the read counter, emit counter and flush counter clear.
  - READ: issue reads for addresses 0..NPIX-1 in order. After the NPIX-th read is issued, move to DRAIN.
  - DRAIN: no reads. Wait until all NPIX image pixels have transferred, then move to FLUSH.
  - FLUSH: push zeros into the buffer under the same credit rule as reads, FLUSH_PIX in total. After the last one transfers, move to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- Credit rule: a read (or zero push) is issued in cycle t only if (occupancy + outstanding − pop_t) < 2. Here occupancy is buffer entries (0..2), outstanding is the read in flight (0/1), and pop_t = `pix_enable`. The buffer never overflows and no returned data is lost.
- Return path: `mem_rdata` is written into the buffer at the end of the cycle after `mem_rd_en`. A push and a pop in the same cycle are both honoured.
- Counters:
  - row/col advance on each image-pixel pop; col wraps at IMG_WIDTH−1 to 0 and row increments.
  - The emit counter is log2(NPIX+FLUSH_PIX) bits wide, with no wrap inside a frame.
- `start` while `busy` is ignored. `ready` may toggle arbitrarily; ordering is preserved.
- `reset`==0 mid-frame: all state returns to IDLE on that edge. Buffer and outstanding flags clear, and the returning RAM word is discarded. No further pix_enable, frame_start or done pulse occurs for that frame.

## Timing
- Reset values (cycle after the reset edge): `mem_rd_en`=0, `mem_addr`=0, `pix_enable`=0, `pix_data`=0, `frame_start`=0, `line_start`=0, `busy`=0, `done`=0.
- `start` accepted at edge E:
  - first `mem_rd_en` in cycle E+1, address 0;
  - first `pix_enable` no earlier than E+3 (read, return, buffer head).
- With `ready` held 1: one read per cycle, one pixel per cycle from E+3. Last image pixel at E+NPIX+2, last flush pixel at E+NPIX+FLUSH_PIX+2, `done` in the following cycle.
- `ready` low for k cycles stalls output by exactly k cycles. At most 2 entries plus 1 in flight are held.
- `start` in the same cycle as `done` is ignored; a new frame needs `start` in IDLE.

## Test plan
- **Frame**: IMG_WIDTH=8, IMG_HEIGHT=4, RAM[a]=a, `ready`=1, pulse `start`.
  - Exactly 32 beats with data 0..31, then 27 beats of 0.
  - frame_start on beat 0; line_start on beats 0, 8, 16, 24.
  - `done` one cycle after beat 58 (total 59 beats); `busy` low afterwards.
- **Backpressure**: same frame with `ready` pseudo-random at 50%.
  - Identical ordered data sequence, no duplicates or drops.
  - `mem_rd_en` never issues when occupancy + outstanding − pop ≥ 2.
- **Stall across a line boundary**: `ready`=0 for 5 cycles exactly when beat 7 is at the head.
  - Beat 7 (data 7) is held stable for 5 cycles.
  - Beat 8 follows with line_start=1.
- **Ignored start**: pulse `start` again at beat 10.
  - No restart: data continues 11, 12, …
  - Exactly one `done` for the frame.
- **Mid-frame reset**: drive `reset`=0 for 1 cycle at beat 20.
  - The next cycle shows all outputs at their reset values; no pix_enable until a new `start`.
  - A new `start` replays the frame from data 0 with frame_start.

Source files
------------

// File: rtl/pixel_stream_reader.sv
// Raster-order frame reader feeding the 7x7 window builder pixel stream.
// Two-entry skid buffer absorbs RAM latency under downstream backpressure.
module pixel_stream_reader #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int ADDR_W     = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ready,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              pix_enable,
  output logic [7:0]        pix_data,
  output logic              frame_start,
  output logic              line_start,
  output logic              busy,
  output logic              done
);

  localparam int NPIX      = IMG_WIDTH * IMG_HEIGHT;
  localparam int FLUSH_PIX = 3 * IMG_WIDTH + 3;
  localparam int TOTAL     = NPIX + FLUSH_PIX;
  localparam int CW        = $clog2(TOTAL + 1);
  localparam int XW        = $clog2(IMG_WIDTH);

  localparam logic [CW-1:0] NPIX_C  = CW'(NPIX);
  localparam logic [CW-1:0] LAST_RD = CW'(NPIX - 1);
  localparam logic [CW-1:0] TOT_C   = CW'(TOTAL);
  localparam logic [CW-1:0] LAST_PX = CW'(TOTAL - 1);
  localparam logic [XW-1:0] COL_MAX = XW'(IMG_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] iss_q, iss_d;
  logic [CW-1:0] emit_q, emit_d;
  logic [XW-1:0] col_q, col_d;
  logic [1:0]    occ_q, occ_d;
  logic          pend_q, pend_d;
  logic          pzero_q, pzero_d;
  logic [7:0]    buf0_q, buf0_d;
  logic [7:0]    buf1_q, buf1_d;

  logic       pop;
  logic       push;
  logic [7:0] pdat;
  logic       want_rd;
  logic       want_zero;
  logic       credit_ok;
  logic       issue;
  logic       start_acc;

  assign pop  = (occ_q != 2'd0) && ready;
  assign push = pend_q;
  assign pdat = pzero_q ? 8'd0 : mem_rdata;

  // Zero pushes may begin in DRAIN so the flush follows the image gaplessly.
  assign want_rd   = (state_q == S_READ);
  assign want_zero = ((state_q == S_DRAIN) || (state_q == S_FLUSH))
                     && (iss_q < TOT_C);
  assign credit_ok = (({1'b0, occ_q} + {2'b0, pend_q}) - {2'b0, pop})
                     < 3'd2;
  assign issue     = (want_rd || want_zero) && credit_ok;
  assign start_acc = (state_q == S_IDLE) && start;

  assign mem_rd_en   = want_rd && credit_ok;
  assign mem_addr    = mem_rd_en ? ADDR_W'(iss_q) : '0;
  assign pix_enable  = pop;
  assign pix_data    = (occ_q != 2'd0) ? buf0_q : 8'd0;
  assign frame_start = pop && (emit_q == '0);
  assign line_start  = pop && (emit_q < NPIX_C) && (col_q == '0);
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_READ;
      S_READ:  if (issue && (iss_q == LAST_RD)) state_d = S_DRAIN;
      S_DRAIN: if (pop && (emit_q == LAST_RD)) state_d = S_FLUSH;
      S_FLUSH: if (pop && (emit_q == LAST_PX)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    iss_d  = iss_q;
    emit_d = emit_q;
    col_d  = col_q;
    if (start_acc) begin
      iss_d  = '0;
      emit_d = '0;
      col_d  = '0;
    end else begin
      if (issue) iss_d = iss_q + 1'b1;
      if (pop) emit_d = emit_q + 1'b1;
      if (pop && (emit_q < NPIX_C)) begin
        col_d = (col_q == COL_MAX) ? '0 : col_q + 1'b1;
      end
    end
  end

  always_comb begin
    occ_d   = occ_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    pend_d  = issue;
    pzero_d = want_zero;
    unique case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = pdat;
        else buf1_d = pdat;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = pdat;
        end else begin
          buf0_d = buf1_q;
          buf1_d = pdat;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      iss_q   <= '0;
      emit_q  <= '0;
      col_q   <= '0;
      occ_q   <= 2'd0;
      pend_q  <= 1'b0;
      pzero_q <= 1'b0;
      buf0_q  <= 8'd0;
      buf1_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      iss_q   <= iss_d;
      emit_q  <= emit_d;
      col_q   <= col_d;
      occ_q   <= occ_d;
      pend_q  <= pend_d;
      pzero_q <= pzero_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
    end
  end

endmodule

// File: tb/tb_pixel_stream_reader.sv
// Directed bench for pixel_stream_reader on an 8x4 frame with RAM[a]=a.
// Covers latency, backpressure, line-boundary stall, ignored start, reset.
module tb_pixel_stream_reader;

  localparam int W   = 8;
  localparam int H   = 4;
  localparam int AW  = 5;
  localparam int NP  = W * H;
  localparam int FL  = 3 * W + 3;
  localparam int TOT = NP + FL;

  typedef struct {
    int         beat;
    logic [7:0] data;
    logic       fs;
    logic       ls;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          ready = 1'b0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata = 8'd0;
  logic          pix_enable;
  logic [7:0]    pix_data;
  logic          frame_start;
  logic          line_start;
  logic          busy;
  logic          done;

  pixel_stream_reader #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .ADDR_W    (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ready      (ready),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .pix_enable (pix_enable),
    .pix_data   (pix_data),
    .frame_start(frame_start),
    .line_start (line_start),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_rdata <= {3'b000, mem_addr};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic [7:0] cap_d[$];
  logic       cap_fs[$];
  logic       cap_ls[$];
  int         cap_c[$];
  int done_cnt, done_cyc, rd_cyc, rd_seen, rd_n, pop_n, viol;
  int t0;

  always @(negedge clk) begin
    if (mem_rd_en) begin
      if (rd_n - pop_n - (pix_enable ? 1 : 0) >= 2) viol++;
      if (rd_seen == 0) begin
        rd_seen = 1;
        rd_cyc  = cyc;
      end
      rd_n++;
    end
    if (pix_enable) begin
      cap_d.push_back(pix_data);
      cap_fs.push_back(frame_start);
      cap_ls.push_back(line_start);
      cap_c.push_back(cyc);
      pop_n++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear();
    cap_d.delete();
    cap_fs.delete();
    cap_ls.delete();
    cap_c.delete();
    done_cnt = 0;
    done_cyc = 0;
    rd_cyc   = 0;
    rd_seen  = 0;
    rd_n     = 0;
    pop_n    = 0;
    viol     = 0;
  endtask

  task automatic start_frame();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(string nm, int maxc, logic rnd);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      if (rnd) ready = 1'($urandom_range(0, 1));
      n++;
    end while (!done && n < maxc);
    chk(nm, done, 1);
  endtask

  task automatic wait_head(string nm, logic [7:0] v);
    int n = 0;
    while (pix_data !== v && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, pix_data, v);
  endtask

  task automatic check_seq(string nm);
    int e = 0;
    chk({nm, "_beats"}, cap_d.size(), TOT);
    for (int i = 0; i < cap_d.size() && i < TOT; i++) begin
      logic [7:0] ed;
      ed = (i < NP) ? 8'(i) : 8'd0;
      if (cap_d[i] !== ed) e++;
      if (cap_fs[i] !== (i == 0)) e++;
      if (cap_ls[i] !== (i < NP && i % W == 0)) e++;
    end
    chk({nm, "_order"}, e, 0);
    chk({nm, "_done_cnt"}, done_cnt, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[10];
    int   r0;
    int   n0;
    int   d0;
    int   st;
    vt[0] = '{0,  8'd0,  1'b1, 1'b1};
    vt[1] = '{1,  8'd1,  1'b0, 1'b0};
    vt[2] = '{7,  8'd7,  1'b0, 1'b0};
    vt[3] = '{8,  8'd8,  1'b0, 1'b1};
    vt[4] = '{16, 8'd16, 1'b0, 1'b1};
    vt[5] = '{24, 8'd24, 1'b0, 1'b1};
    vt[6] = '{31, 8'd31, 1'b0, 1'b0};
    vt[7] = '{32, 8'd0,  1'b0, 1'b0};
    vt[8] = '{45, 8'd0,  1'b0, 1'b0};
    vt[9] = '{58, 8'd0,  1'b0, 1'b0};
    clear();

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", int'({mem_rd_en, mem_addr, pix_enable, pix_data,
                          frame_start, line_start, busy, done}), 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    ready = 1'b1;

    // full frame, ready held high
    clear();
    start_frame();
    chk("t1_busy_on", busy, 1);
    wait_done("t1_done_seen", 300, 1'b0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    r0 = rd_n;
    repeat (10) @(posedge clk);
    #1;
    chk("t1_busy_off", busy, 0);
    chk("t1_start_at_done", rd_n, r0);
    chk("t1_first_rd", rd_cyc - t0, 0);
    check_seq("t1");
    if (cap_c.size() == TOT) begin
      chk("t1_first_pix", cap_c[0] - t0, 2);
      chk("t1_last_img", cap_c[NP-1] - t0, NP + 1);
      chk("t1_last_pix", cap_c[TOT-1] - t0, TOT + 1);
      chk("t1_done_cyc", done_cyc - t0, TOT + 2);
      for (int i = 0; i < 10; i++) begin
        int b;
        b = vt[i].beat;
        chk($sformatf("vec%0d_data", b), cap_d[b], vt[i].data);
        chk($sformatf("vec%0d_fs", b), cap_fs[b], vt[i].fs);
        chk($sformatf("vec%0d_ls", b), cap_ls[b], vt[i].ls);
      end
    end
    chk("t1_credit", viol, 0);

    // random backpressure
    clear();
    start_frame();
    wait_done("t2_done_seen", 2000, 1'b1);
    ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_seq("t2");
    chk("t2_credit", viol, 0);
    chk("t2_reads", rd_n, NP);

    // stall across line boundary, then ignored start
    clear();
    start_frame();
    wait_head("t3_head7", 8'd7);
    ready = 1'b0;
    st = 0;
    repeat (5) begin
      @(negedge clk);
      if (!pix_enable && pix_data == 8'd7) st++;
      @(posedge clk);
      #1;
    end
    ready = 1'b1;
    chk("t3_hold7", st, 5);
    wait_head("t3_head10", 8'd10);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("t3_done_seen", 300, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    check_seq("t3");
    if (cap_c.size() > 11) begin
      chk("t3_gap7", cap_c[7] - cap_c[6], 6);
      chk("t3_gap8", cap_c[8] - cap_c[7], 1);
      chk("t3_ls8", cap_ls[8], 1);
      chk("t3_d11", cap_d[11], 11);
    end

    // mid-frame reset, then replay
    clear();
    start_frame();
    wait_head("t4_head20", 8'd20);
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    chk("t4_rst_outs", int'({mem_rd_en, mem_addr, pix_enable, pix_data,
                             frame_start, line_start, busy, done}), 0);
    n0 = cap_d.size();
    d0 = done_cnt;
    repeat (30) @(posedge clk);
    #1;
    chk("t4_no_pix", cap_d.size(), n0);
    chk("t4_no_done", done_cnt, d0);
    chk("t4_idle", busy, 0);
    clear();
    start_frame();
    wait_done("t4_done_seen", 300, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_seq("t4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
